sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Initiator-side controller for the team's single-port SRAM macro model (low-active chip enable, gwen 0 = write / 1 = read, read data registered one cycle after the sampling edge).
- Accepts read/write requests on a valid/ready interface and drives the SRAM port from registers.
- Captures read data into a response FIFO, with credit-based backpressure so no read result is ever dropped.
- Provides a zero-fill (clear) sequencer used at octree buffer init.

Parameters:
- data_width, 64, width of SRAM word.
- addr_width, 10, SRAM address width.
- depth, 1 << addr_width, number of words the clear sequence covers.
- rsp_depth, 4, response FIFO entries (power of two, ≥ 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid & ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  addr_width  request address.
- req_wdata  in  data_width  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes rsp_data.
- rsp_data  out  data_width  read data, in request order.
- clear_start  in  1  pulse: begin zero-fill.
- clear_busy  out  1  high during clear.
- clear_done  out  1  one-cycle pulse after last clear write issued.
- sram_cen_n  out  1  to SRAM cen_n.
- sram_gwen  out  1  to SRAM gwen.
- sram_addr  out  addr_width  to SRAM addr.
- sram_data_in  out  data_width  to SRAM data_in.
- sram_data_out  in  data_width  from SRAM data_out.

Behaviour:
- Reset (async, rst=1): state IDLE; sram_cen_n=1, sram_gwen=1, sram_addr=0, sram_data_in=0; FIFO empty; rsp_valid=0; in-flight count 0; clear_busy=0, clear_done=0; rsp_data=0.
- Issue stage: all sram_* outputs are registered. A request accepted at edge t drives the SRAM during cycle t..t+1; the SRAM samples it at edge t+1. In cycles with nothing issued, sram_cen_n=1 and sram_gwen=1.
- Read path:
  - SRAM data_out is valid after edge t+1; the controller writes it into the FIFO at edge t+2.
  - rsp_valid is high in the cycle after edge t+2, so read latency is 2 cycles, accept to rsp_valid.
  - A capture-pending flag (shift of issued-read bits) marks which cycles carry read data.
  - Writes produce no response.
- Credits:
  - inflight = reads in issue register + reads awaiting capture (0..2).
  - req_ready = (state==IDLE) & !clear_start & (fifo_count + inflight < rsp_depth).
  - The credit check uses registered counts only; a pop in the same cycle does not free a credit until the next cycle. There is no combinational path rsp_ready→req_ready.
  - The credit check applies to writes as well; req_ready must not depend on req_we.
- FIFO:
  - Same-cycle push and pop are allowed; count is unchanged.
  - Pop when empty or push when full cannot occur by construction; assert in simulation.
  - rsp_data shows the head entry, valid only while rsp_valid.
- FSM:
  - IDLE→CLEAR on clear_start. clear_start is ignored in CLEAR.
  - CLEAR:
    - Issues one write per cycle: addr 0,1,…,depth-1, data 0.
    - Reads accepted before entry still complete and still return responses.
    - req_ready=0; clear_busy=1.
  - After issuing addr depth-1: next state IDLE, clear_done=1 for exactly one cycle.
  - Clear address counter wraps to 0.
  - clear_start with req_valid in the same cycle: clear wins and the request is not accepted.
- Ordering: responses are returned strictly in request order. A read after a write to the same address returns the new data, because the SRAM sees the write first.
- Reset mid-operation: pending reads, FIFO contents and clear progress are discarded; outputs return to reset values immediately.

Test Plan:
- Write 0xDEAD_BEEF to addr 5, then read addr 5 back-to-back -> one issue per cycle; rsp_valid 2 cycles after read accept; rsp_data=0xDEAD_BEEF.
- Reads of addr 1,2,3,4,5,6 with rsp_ready=0 (addr k preloaded with data k) -> req_ready drops after 4 accepts; FIFO holds 1,2,3,4; raising rsp_ready returns 1..6 in order with none lost.
- rsp_ready toggling every cycle during 20 random read/write ops against a reference memory -> all data matches and ordering is preserved.
- clear_start with depth=16 after preloading nonzero data -> clear_busy for 16 cycles, sram_addr 0..15 with gwen=0 and data 0, clear_done single pulse; reading every address returns 0.
- clear_start asserted with req_valid in the same cycle, and during CLEAR -> request not accepted until IDLE; a second clear_start during CLEAR has no effect.
- rst asserted mid-read and mid-clear -> sram_cen_n=1, rsp_valid=0, clear_busy=0 within the same cycle; normal operation after release.

Source files
------------

// File: rtl/sram_ctrl.sv
// Initiator-side controller for the single-port SRAM macro: registered issue stage,
// credit-protected read-response FIFO and a zero-fill clear sequencer.
module sram_ctrl #(
    parameter int unsigned data_width = 64,
    parameter int unsigned addr_width = 10,
    parameter int unsigned depth      = 1 << addr_width,
    parameter int unsigned rsp_depth  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [addr_width-1:0] req_addr,
    input  logic [data_width-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_data,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  sram_cen_n,
    output logic                  sram_gwen,
    output logic [addr_width-1:0] sram_addr,
    output logic [data_width-1:0] sram_data_in,
    input  logic [data_width-1:0] sram_data_out
);

    localparam int unsigned ptr_w = (rsp_depth > 1) ? $clog2(rsp_depth) : 1;
    localparam int unsigned cnt_w = $clog2(rsp_depth + 1);
    localparam int unsigned crd_w = cnt_w + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state;
    logic                    rd_issue;
    logic                    rd_pend;
    logic [addr_width-1:0]   clr_addr;

    logic [data_width-1:0]   fifo_mem [rsp_depth];
    logic [ptr_w-1:0]        wr_ptr;
    logic [ptr_w-1:0]        rd_ptr;
    logic [cnt_w-1:0]        fifo_count;
    logic [cnt_w-1:0]        count_nxt;

    logic                    accept;
    logic                    push;
    logic                    pop;
    logic [crd_w-1:0]        credit_used;

    // Credits count FIFO entries plus reads still travelling through the SRAM.
    assign credit_used = crd_w'(fifo_count) + crd_w'(rd_issue) + crd_w'(rd_pend);
    assign req_ready   = (state == IDLE) && !clear_start && (credit_used < crd_w'(rsp_depth));
    assign accept      = req_valid && req_ready;
    assign push        = rd_pend;
    assign pop         = rsp_valid && rsp_ready;
    assign rsp_data    = fifo_mem[rd_ptr];

    // Control FSM and registered SRAM issue stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sram_cen_n   <= 1'b1;
            sram_gwen    <= 1'b1;
            sram_addr    <= '0;
            sram_data_in <= '0;
            rd_issue     <= 1'b0;
            rd_pend      <= 1'b0;
            clr_addr     <= '0;
            clear_busy   <= 1'b0;
            clear_done   <= 1'b0;
        end else begin
            rd_pend    <= rd_issue;
            rd_issue   <= 1'b0;
            sram_cen_n <= 1'b1;
            sram_gwen  <= 1'b1;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= CLEAR;
                        clr_addr   <= '0;
                        clear_busy <= 1'b1;
                    end else if (accept) begin
                        sram_cen_n   <= 1'b0;
                        sram_gwen    <= !req_we;
                        sram_addr    <= req_addr;
                        sram_data_in <= req_wdata;
                        rd_issue     <= !req_we;
                    end
                end
                CLEAR: begin
                    sram_cen_n   <= 1'b0;
                    sram_gwen    <= 1'b0;
                    sram_addr    <= clr_addr;
                    sram_data_in <= '0;
                    if (clr_addr == addr_width'(depth - 1)) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                        clr_addr   <= '0;
                    end else begin
                        clr_addr <= clr_addr + addr_width'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        count_nxt = fifo_count;
        case ({push, pop})
            2'b10:   count_nxt = fifo_count + cnt_w'(1);
            2'b01:   count_nxt = fifo_count - cnt_w'(1);
            default: count_nxt = fifo_count;
        endcase
    end

    // Response FIFO; capture happens the edge after the SRAM registers its output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rsp_valid  <= 1'b0;
            for (int i = 0; i < int'(rsp_depth); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sram_data_out;
                wr_ptr           <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            fifo_count <= count_nxt;
            rsp_valid  <= (count_nxt != '0);
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_count == cnt_w'(rsp_depth))));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && (fifo_count == '0)));

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural single-port SRAM and a reference memory.
module tb_sram_ctrl;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned RD    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic          sram_cen_n;
    logic          sram_gwen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data_in;
    logic [DW-1:0] sram_data_out;

    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    logic [DW-1:0] exp_q    [$];

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_pop  = 0;
    logic last_acc;

    sram_ctrl #(
        .data_width (DW),
        .addr_width (AW),
        .depth      (DEPTH),
        .rsp_depth  (RD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .clear_start   (clear_start),
        .clear_busy    (clear_busy),
        .clear_done    (clear_done),
        .sram_cen_n    (sram_cen_n),
        .sram_gwen     (sram_gwen),
        .sram_addr     (sram_addr),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out)
    );

    always #5 clk = ~clk;

    // SRAM macro: output registered at the sampling edge of a read.
    always @(posedge clk) begin
        if (!sram_cen_n) begin
            if (!sram_gwen) sram_mem[sram_addr] <= sram_data_in;
            else            sram_data_out       <= sram_mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Evaluate handshakes for the coming edge, update the model, then advance one cycle.
    task automatic tick();
        #1;
        last_acc = req_valid && req_ready;
        if (rsp_valid && rsp_ready) begin
            n_pop++;
            if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
            else                   chk("rsp_data", rsp_data, exp_q.pop_front());
        end
        if (last_acc) begin
            if (req_we) ref_mem[req_addr] = req_wdata;
            else        exp_q.push_back(ref_mem[req_addr]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t;
        t         = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        do begin
            tick();
            t++;
        end while (!last_acc && t < 50);
        if (!last_acc) chk("op_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        rsp_ready = 1'b1;
        repeat (8) tick();
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        int ops;
        int t;
        int busy_cnt;
        int done_cnt;
        int pop0;
        logic any_acc;

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        rsp_ready   = 1'b0;
        clear_start = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cen_n", 64'(sram_cen_n), 64'd1);
        chk("rst_gwen", 64'(sram_gwen), 64'd1);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_data_in", sram_data_in, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_busy", 64'(clear_busy), 64'd0);
        chk("rst_done", 64'(clear_done), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);

        // Write then back-to-back read of the same address
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd5;
        req_wdata = 64'hDEAD_BEEF;
        tick();
        chk("wr_accept", 64'(last_acc), 64'd1);
        chk("wr_cen_n", 64'(sram_cen_n), 64'd0);
        chk("wr_gwen", 64'(sram_gwen), 64'd0);
        chk("wr_addr", 64'(sram_addr), 64'd5);
        chk("wr_data_in", sram_data_in, 64'hDEAD_BEEF);
        req_we = 1'b0;
        tick();
        chk("rd_accept", 64'(last_acc), 64'd1);
        chk("rd_cen_n", 64'(sram_cen_n), 64'd0);
        chk("rd_gwen", 64'(sram_gwen), 64'd1);
        chk("rd_lat0_valid", 64'(rsp_valid), 64'd0);
        req_valid = 1'b0;
        tick();
        chk("rd_lat1_valid", 64'(rsp_valid), 64'd0);
        chk("idle_cen_n", 64'(sram_cen_n), 64'd1);
        tick();
        chk("rd_lat2_valid", 64'(rsp_valid), 64'd1);
        chk("rd_lat2_data", rsp_data, 64'hDEAD_BEEF);
        rsp_ready = 1'b1;
        tick();
        chk("rd_popped_valid", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;

        // Credit backpressure: preload addr k with k, read 1..6 with the consumer stalled
        for (int k = 0; k < 8; k++) do_op(1'b1, AW'(k), DW'(k));
        acc_cnt   = 0;
        pop0      = n_pop;
        req_valid = 1'b1;
        req_we    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            req_addr = AW'(1 + acc_cnt);
            tick();
            if (last_acc) acc_cnt++;
        end
        chk("credit_accepts", 64'(acc_cnt), 64'd4);
        chk("credit_req_ready", 64'(req_ready), 64'd0);
        chk("credit_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("credit_head", rsp_data, 64'd1);
        rsp_ready = 1'b1;
        t = 0;
        while (acc_cnt < 6 && t < 20) begin
            req_addr = AW'(1 + acc_cnt);
            tick();
            if (last_acc) acc_cnt++;
            t++;
        end
        req_valid = 1'b0;
        chk("credit_all_accepted", 64'(acc_cnt), 64'd6);
        drain("credit");
        chk("credit_pops", 64'(n_pop - pop0), 64'd6);

        // Random ops against the reference memory with rsp_ready toggling
        rsp_ready = 1'b0;
        ops       = 0;
        t         = 0;
        req_valid = 1'b1;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom_range(0, 7));
        req_wdata = {$urandom, $urandom};
        while (ops < 20 && t < 400) begin
            rsp_ready = ~rsp_ready;
            tick();
            t++;
            if (last_acc) begin
                ops++;
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = AW'($urandom_range(0, 7));
                req_wdata = {$urandom, $urandom};
            end
        end
        req_valid = 1'b0;
        chk("rand_ops_done", 64'(ops), 64'd20);
        drain("rand");

        // Zero-fill after nonzero preload; an earlier read must still return old data
        for (int a = 0; a < int'(DEPTH); a++) do_op(1'b1, AW'(a), 64'hA5A5_0000_0000_0000 | DW'(a + 1));
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd2;
        tick();
        chk("pre_clear_rd_accept", 64'(last_acc), 64'd1);
        req_addr    = 4'd3;
        clear_start = 1'b1;
        tick();
        chk("clear_wins_req", 64'(last_acc), 64'd0);
        clear_start = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        busy_cnt = clear_busy ? 1 : 0;
        done_cnt = 0;
        any_acc  = 1'b0;
        chk("clear_busy_start", 64'(clear_busy), 64'd1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            clear_start = (i == 5);
            tick();
            if (last_acc) any_acc = 1'b1;
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
            chk("clear_addr", 64'(sram_addr), 64'(i));
            chk("clear_gwen", 64'(sram_gwen), 64'd0);
            chk("clear_cen_n", 64'(sram_cen_n), 64'd0);
            chk("clear_data_in", sram_data_in, 64'd0);
        end
        clear_start = 1'b0;
        chk("clear_busy_cycles", 64'(busy_cnt), 64'd16);
        chk("clear_done_pulses", 64'(done_cnt), 64'd1);
        chk("clear_no_accept", 64'(any_acc), 64'd0);
        chk("clear_done_last", 64'(clear_done), 64'd1);
        chk("post_clear_ready", 64'(req_ready), 64'd1);
        tick();
        chk("post_clear_accept", 64'(last_acc), 64'd1);
        chk("clear_done_drop", 64'(clear_done), 64'd0);
        req_valid = 1'b0;
        for (int a = 0; a < int'(DEPTH); a++) do_op(1'b0, AW'(a), '0);
        drain("clear");

        // Reset with reads in flight and a response waiting
        rsp_ready = 1'b0;
        do_op(1'b0, 4'd4, '0);
        do_op(1'b0, 4'd5, '0);
        do_op(1'b0, 4'd6, '0);
        chk("midrd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("midrd_cen_n", 64'(sram_cen_n), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrd_rst_cen_n", 64'(sram_cen_n), 64'd1);
        chk("midrd_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrd_rst_rsp_data", rsp_data, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a clear
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        tick();
        tick();
        chk("midclr_busy", 64'(clear_busy), 64'd1);
        chk("midclr_cen_n", 64'(sram_cen_n), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("midclr_rst_busy", 64'(clear_busy), 64'd0);
        chk("midclr_rst_cen_n", 64'(sram_cen_n), 64'd1);
        chk("midclr_rst_gwen", 64'(sram_gwen), 64'd1);
        chk("midclr_rst_done", 64'(clear_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal operation after reset
        rsp_ready = 1'b1;
        do_op(1'b1, 4'd7, 64'h1234_5678_9ABC_DEF0);
        do_op(1'b0, 4'd7, '0);
        pop0 = n_pop;
        drain("post_rst");
        chk("post_rst_pops", 64'(n_pop - pop0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
